// File: rtl/acc_multi_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : acc_multi_dispatch                                         |
// | Description : Dispatches issue-stage accelerator requests to NR_ACC      |
// |               channels through one-entry per-channel buffers with        |
// |               outstanding-op credit limits, and merges the channel       |
// |               responses round-robin into one registered response port.   |
// | Option      : ACC_DISPATCH_PERF_EN enables the request-stall counter on  |
// |               perf_stall_o (tied to zero otherwise).                     |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module acc_multi_dispatch #(
  parameter  int NR_ACC    = 2,
  parameter  int MAX_OUTST = 4,
  parameter  int TID_W     = 3,
  parameter  int XLEN      = 64,
  localparam int c_sel_w   = (NR_ACC > 1) ? $clog2(NR_ACC) : 1,
  localparam int c_req_w   = 32 + 2 * XLEN + TID_W,
  localparam int c_rsp_w   = XLEN + TID_W
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        req_valid_i,
  output logic                        req_ready_o,
  input  logic [c_sel_w-1:0]          req_sel_i,
  input  logic [31:0]                 req_insn_i,
  input  logic [XLEN-1:0]             req_rs1_i,
  input  logic [XLEN-1:0]             req_rs2_i,
  input  logic [TID_W-1:0]            req_tid_i,
  output logic [NR_ACC-1:0]           acc_req_valid_o,
  input  logic [NR_ACC-1:0]           acc_req_ready_i,
  output logic [NR_ACC*c_req_w-1:0]   acc_req_data_o,
  input  logic [NR_ACC-1:0]           acc_resp_valid_i,
  output logic [NR_ACC-1:0]           acc_resp_ready_o,
  input  logic [NR_ACC*c_rsp_w-1:0]   acc_resp_data_i,
  output logic                        resp_valid_o,
  input  logic                        resp_ready_i,
  output logic [XLEN-1:0]             resp_result_o,
  output logic [TID_W-1:0]            resp_tid_o,
  output logic [c_sel_w-1:0]          resp_ch_o,
  output logic                        busy_o,
  output logic [31:0]                 perf_stall_o
);

  localparam int                 c_cnt_w = $clog2(MAX_OUTST + 1);
  localparam logic [c_sel_w-1:0] c_last  = c_sel_w'(NR_ACC - 1);

  logic [NR_ACC-1:0]  r_buf_vld;
  logic [c_req_w-1:0] r_buf_data  [NR_ACC];
  logic [c_cnt_w-1:0] r_outst     [NR_ACC];
  logic [c_cnt_w-1:0] w_outst_nxt [NR_ACC];
  logic [c_cnt_w:0]   w_sum;
  logic [NR_ACC-1:0]  w_issue;
  logic [NR_ACC-1:0]  w_outst_nz;
  logic [NR_ACC-1:0]  w_gnt_oh;
  logic               w_sel_hit;
  logic               w_sel_free;
  logic               w_sel_room;
  logic               w_accept;
  logic               w_take;
  logic               w_gnt_any;
  logic               w_hi_any;
  logic [c_sel_w-1:0] w_hi_idx;
  logic [c_sel_w-1:0] w_lo_idx;
  logic [c_sel_w-1:0] w_gnt_idx;
  logic [c_rsp_w-1:0] w_hi_data;
  logic [c_rsp_w-1:0] w_lo_data;
  logic [c_rsp_w-1:0] w_gnt_data;
  logic               r_rsp_vld;
  logic [c_rsp_w-1:0] r_rsp_data;
  logic [c_sel_w-1:0] r_rsp_ch;
  logic [c_sel_w-1:0] r_ptr;

  assign w_issue = r_buf_vld & acc_req_ready_i;

  // Look up the selected channel: buffer free (or draining now) and credit left.
  // The buffered entry counts against the credit even while it issues.
  always_comb begin
    w_sel_hit  = 1'b0;
    w_sel_free = 1'b0;
    w_sel_room = 1'b0;
    for (int c = 0; c < NR_ACC; c++) begin
      if (req_sel_i == c_sel_w'(c)) begin
        w_sel_hit  = 1'b1;
        w_sel_free = !r_buf_vld[c] || w_issue[c];
        w_sel_room = ({1'b0, r_outst[c]} + {{c_cnt_w{1'b0}}, r_buf_vld[c]})
                     < (c_cnt_w + 1)'(MAX_OUTST);
      end
    end
  end

  assign req_ready_o = !flush_i && w_sel_hit && w_sel_free && w_sel_room;
  assign w_accept    = req_valid_i && req_ready_o;

  // Per-channel request buffer: load on accept, drop on issue or flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_buf_vld <= '0;
      for (int c = 0; c < NR_ACC; c++) r_buf_data[c] <= '0;
    end else begin
      for (int c = 0; c < NR_ACC; c++) begin
        if (w_accept && (req_sel_i == c_sel_w'(c))) begin
          r_buf_vld[c]  <= 1'b1;
          r_buf_data[c] <= {req_insn_i, req_rs1_i, req_rs2_i, req_tid_i};
        end else if (w_issue[c] || flush_i) begin
          r_buf_vld[c]  <= 1'b0;
        end
      end
    end
  end

  assign acc_req_valid_o = r_buf_vld;

  generate
    for (genvar c = 0; c < NR_ACC; c++) begin : g_req_data
      assign acc_req_data_o[c*c_req_w +: c_req_w] = r_buf_data[c];
    end
  endgenerate

  // Round-robin search: lowest requester at/above the pointer, else lowest overall.
  always_comb begin
    w_hi_any  = 1'b0;
    w_hi_idx  = '0;
    w_hi_data = '0;
    w_lo_idx  = '0;
    w_lo_data = '0;
    for (int c = NR_ACC - 1; c >= 0; c--) begin
      if (acc_resp_valid_i[c]) begin
        w_lo_idx  = c_sel_w'(c);
        w_lo_data = acc_resp_data_i[c*c_rsp_w +: c_rsp_w];
        if (c_sel_w'(c) >= r_ptr) begin
          w_hi_any  = 1'b1;
          w_hi_idx  = c_sel_w'(c);
          w_hi_data = acc_resp_data_i[c*c_rsp_w +: c_rsp_w];
        end
      end
    end
  end

  assign w_take     = !r_rsp_vld || resp_ready_i;
  assign w_gnt_any  = w_take && (|acc_resp_valid_i);
  assign w_gnt_idx  = w_hi_any ? w_hi_idx  : w_lo_idx;
  assign w_gnt_data = w_hi_any ? w_hi_data : w_lo_data;

  generate
    for (genvar c = 0; c < NR_ACC; c++) begin : g_gnt
      assign w_gnt_oh[c] = w_gnt_any && (w_gnt_idx == c_sel_w'(c));
    end
  endgenerate

  assign acc_resp_ready_o = w_gnt_oh;

  // Outstanding count: +1 on issue, -1 on granted response, floor at zero.
  always_comb begin
    w_sum = '0;
    for (int c = 0; c < NR_ACC; c++) begin
      w_sum = {1'b0, r_outst[c]} + {{c_cnt_w{1'b0}}, w_issue[c]};
      if (w_gnt_oh[c] && (w_sum != '0)) w_sum = w_sum - (c_cnt_w + 1)'(1);
      w_outst_nxt[c] = w_sum[c_cnt_w-1:0];
      w_outst_nz[c]  = (r_outst[c] != '0);
    end
  end

  // Outstanding counter registers; flush never touches them.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int c = 0; c < NR_ACC; c++) r_outst[c] <= '0;
    end else begin
      for (int c = 0; c < NR_ACC; c++) r_outst[c] <= w_outst_nxt[c];
    end
  end

  // Response register and round-robin pointer; held while stalled downstream.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rsp_vld  <= 1'b0;
      r_rsp_data <= '0;
      r_rsp_ch   <= '0;
      r_ptr      <= '0;
    end else if (w_take) begin
      r_rsp_vld <= w_gnt_any;
      if (w_gnt_any) begin
        r_rsp_data <= w_gnt_data;
        r_rsp_ch   <= w_gnt_idx;
        r_ptr      <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + c_sel_w'(1);
      end
    end
  end

  assign resp_valid_o  = r_rsp_vld;
  assign resp_result_o = r_rsp_data[c_rsp_w-1:TID_W];
  assign resp_tid_o    = r_rsp_data[TID_W-1:0];
  assign resp_ch_o     = r_rsp_ch;
  assign busy_o        = (|r_buf_vld) || (|w_outst_nz);

`ifdef ACC_DISPATCH_PERF_EN
  logic [31:0] r_perf;

  // Count cycles where a request is presented but not accepted.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_perf <= '0;
    end else if (req_valid_i && !req_ready_o) begin
      r_perf <= r_perf + 32'd1;
    end
  end

  assign perf_stall_o = r_perf;
`else
  assign perf_stall_o = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_acc_multi_dispatch.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_acc_multi_dispatch                                      |
// | Description : Self-checking bench for acc_multi_dispatch: directed       |
// |               scenarios plus randomized traffic against a behavioural    |
// |               reference model.                                           |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_acc_multi_dispatch;

  localparam int N    = 2;
  localparam int MAXO = 4;
  localparam int TW   = 3;
  localparam int XL   = 64;
  localparam int RQW  = 32 + 2 * XL + TW;
  localparam int RSW  = XL + TW;
`ifdef ACC_DISPATCH_PERF_EN
  localparam int EXP_STALL = 10;
`else
  localparam int EXP_STALL = 0;
`endif

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b0;
  logic             flush_i;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [0:0]       req_sel_i;
  logic [31:0]      req_insn_i;
  logic [XL-1:0]    req_rs1_i;
  logic [XL-1:0]    req_rs2_i;
  logic [TW-1:0]    req_tid_i;
  logic [N-1:0]     acc_req_valid_o;
  logic [N-1:0]     acc_req_ready_i;
  logic [N*RQW-1:0] acc_req_data_o;
  logic [N-1:0]     acc_resp_valid_i;
  logic [N-1:0]     acc_resp_ready_o;
  logic [N*RSW-1:0] acc_resp_data_i;
  logic             resp_valid_o;
  logic             resp_ready_i;
  logic [XL-1:0]    resp_result_o;
  logic [TW-1:0]    resp_tid_o;
  logic [0:0]       resp_ch_o;
  logic             busy_o;
  logic [31:0]      perf_stall_o;

  int n_vec = 0;
  int n_err = 0;

  acc_multi_dispatch #(.NR_ACC(N), .MAX_OUTST(MAXO), .TID_W(TW), .XLEN(XL)) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .flush_i          (flush_i),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_sel_i        (req_sel_i),
    .req_insn_i       (req_insn_i),
    .req_rs1_i        (req_rs1_i),
    .req_rs2_i        (req_rs2_i),
    .req_tid_i        (req_tid_i),
    .acc_req_valid_o  (acc_req_valid_o),
    .acc_req_ready_i  (acc_req_ready_i),
    .acc_req_data_o   (acc_req_data_o),
    .acc_resp_valid_i (acc_resp_valid_i),
    .acc_resp_ready_o (acc_resp_ready_o),
    .acc_resp_data_i  (acc_resp_data_i),
    .resp_valid_o     (resp_valid_o),
    .resp_ready_i     (resp_ready_i),
    .resp_result_o    (resp_result_o),
    .resp_tid_o       (resp_tid_o),
    .resp_ch_o        (resp_ch_o),
    .busy_o           (busy_o),
    .perf_stall_o     (perf_stall_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic set_idle();
    flush_i          = 1'b0;
    req_valid_i      = 1'b0;
    req_sel_i        = '0;
    req_insn_i       = '0;
    req_rs1_i        = '0;
    req_rs2_i        = '0;
    req_tid_i        = '0;
    acc_req_ready_i  = '0;
    acc_resp_valid_i = '0;
    acc_resp_data_i  = '0;
    resp_ready_i     = 1'b0;
  endtask

  task automatic clk_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    rst_i = 1'b1;
    clk_step();
    clk_step();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    #2 rst_i = 1'b1;
    #1;
    n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL rst_resp_valid: got %b exp 0", resp_valid_o); end
    n_vec++; if (acc_req_valid_o !== 2'b00) begin n_err++; $display("FAIL rst_acc_req_valid: got %b exp 00", acc_req_valid_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b exp 0", busy_o); end
    n_vec++; if (perf_stall_o !== 32'd0) begin n_err++; $display("FAIL rst_perf: got %0d exp 0", perf_stall_o); end
    n_vec++; if ({resp_result_o, resp_tid_o, resp_ch_o} !== '0) begin n_err++; $display("FAIL rst_resp_data: got %h/%h/%h exp 0", resp_result_o, resp_tid_o, resp_ch_o); end
    n_vec++; if (acc_req_data_o !== '0) begin n_err++; $display("FAIL rst_acc_req_data: got %h exp 0", acc_req_data_o); end
    n_vec++; if (acc_resp_ready_o !== 2'b00) begin n_err++; $display("FAIL rst_acc_resp_ready: got %b exp 00", acc_resp_ready_o); end
    clk_step();
    rst_i = 1'b0;
    #1;
    n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL rst_req_ready: got %b exp 1", req_ready_o); end
  endtask

  task automatic test_single();
    logic [RQW-1:0] e_req;
    do_reset();
    req_valid_i = 1'b1; req_sel_i = 1'b1; req_insn_i = 32'h0000_5057;
    req_rs1_i = 64'h1111_2222_3333_4444; req_rs2_i = 64'h5555_6666_7777_8888; req_tid_i = 3'd5;
    acc_req_ready_i = 2'b10;
    e_req = {32'h0000_5057, 64'h1111_2222_3333_4444, 64'h5555_6666_7777_8888, 3'd5};
    #1;
    n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL single_req_ready: got %b exp 1", req_ready_o); end
    clk_step();
    req_valid_i = 1'b0;
    #1;
    n_vec++; if (acc_req_valid_o !== 2'b10) begin n_err++; $display("FAIL single_acc_valid: got %b exp 10", acc_req_valid_o); end
    n_vec++; if (acc_req_data_o[RQW +: RQW] !== e_req) begin n_err++; $display("FAIL single_acc_data: got %h exp %h", acc_req_data_o[RQW +: RQW], e_req); end
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy_buf: got %b exp 1", busy_o); end
    clk_step();
    n_vec++; if (acc_req_valid_o !== 2'b00) begin n_err++; $display("FAIL single_issued: got %b exp 00", acc_req_valid_o); end
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL single_busy_outst: got %b exp 1", busy_o); end
    acc_resp_valid_i = 2'b10; acc_resp_data_i[RSW +: RSW] = {64'hAB, 3'd5}; resp_ready_i = 1'b1;
    #1;
    n_vec++; if (acc_resp_ready_o !== 2'b10) begin n_err++; $display("FAIL single_grant: got %b exp 10", acc_resp_ready_o); end
    clk_step();
    acc_resp_valid_i = 2'b00;
    n_vec++; if (resp_valid_o !== 1'b1) begin n_err++; $display("FAIL single_resp_valid: got %b exp 1", resp_valid_o); end
    n_vec++; if ({resp_result_o, resp_tid_o, resp_ch_o} !== {64'hAB, 3'd5, 1'b1}) begin n_err++; $display("FAIL single_resp_data: got %h/%h/%h exp ab/5/1", resp_result_o, resp_tid_o, resp_ch_o); end
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL single_busy_done: got %b exp 0", busy_o); end
    clk_step();
    n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL single_resp_drained: got %b exp 0", resp_valid_o); end
  endtask

  task automatic test_credit();
    int n_acc;
    do_reset();
    n_acc = 0;
    acc_req_ready_i = 2'b01; req_valid_i = 1'b1; req_sel_i = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (req_ready_o === 1'b1) n_acc++;
      clk_step();
    end
    n_vec++; if (n_acc !== MAXO) begin n_err++; $display("FAIL credit_accepts: got %0d exp %0d", n_acc, MAXO); end
    n_vec++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL credit_ch0_stall: got %b exp 0", req_ready_o); end
    n_vec++; if (acc_req_valid_o !== 2'b00) begin n_err++; $display("FAIL credit_buf_empty: got %b exp 00", acc_req_valid_o); end
    req_sel_i = 1'b1;
    #1;
    n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL credit_ch1_ready: got %b exp 1", req_ready_o); end
    req_valid_i = 1'b0; req_sel_i = 1'b0;
    acc_resp_valid_i = 2'b01; resp_ready_i = 1'b1;
    clk_step();
    acc_resp_valid_i = 2'b00; req_valid_i = 1'b1;
    #1;
    n_vec++; if (req_ready_o !== 1'b1) begin n_err++; $display("FAIL credit_returned: got %b exp 1", req_ready_o); end
  endtask

  task automatic test_rr();
    logic [XL-1:0] e_res;
    do_reset();
    resp_ready_i = 1'b1; acc_resp_valid_i = 2'b11;
    for (int k = 0; k < 4; k++) begin
      acc_resp_data_i = {64'(32'h200 + k), 3'd2, 64'(32'h100 + k), 3'd1};
      #1;
      n_vec++; if (acc_resp_ready_o !== ((k % 2 == 0) ? 2'b01 : 2'b10)) begin n_err++; $display("FAIL rr_grant%0d: got %b", k, acc_resp_ready_o); end
      clk_step();
      e_res = (k % 2 == 0) ? 64'(32'h100 + k) : 64'(32'h200 + k);
      n_vec++; if ({resp_valid_o, resp_ch_o, resp_result_o} !== {1'b1, 1'(k % 2), e_res}) begin n_err++; $display("FAIL rr_resp%0d: got %b/%h/%h exp 1/%0d/%h", k, resp_valid_o, resp_ch_o, resp_result_o, k % 2, e_res); end
    end
    resp_ready_i = 1'b0;
    for (int j = 0; j < 3; j++) begin
      acc_resp_data_i = {64'(32'h300 + j), 3'd6, 64'(32'h400 + j), 3'd7};
      #1;
      n_vec++; if (acc_resp_ready_o !== 2'b00) begin n_err++; $display("FAIL rr_hold_grant%0d: got %b exp 00", j, acc_resp_ready_o); end
      clk_step();
      n_vec++; if ({resp_valid_o, resp_ch_o, resp_result_o, resp_tid_o} !== {1'b1, 1'b1, 64'h203, 3'd2}) begin n_err++; $display("FAIL rr_hold_data%0d: got %b/%h/%h/%h exp 1/1/203/2", j, resp_valid_o, resp_ch_o, resp_result_o, resp_tid_o); end
    end
    resp_ready_i = 1'b1;
    #1;
    n_vec++; if (acc_resp_ready_o !== 2'b01) begin n_err++; $display("FAIL rr_resume: got %b exp 01", acc_resp_ready_o); end
  endtask

  task automatic test_flush();
    do_reset();
    acc_req_ready_i = 2'b01; req_valid_i = 1'b1; req_sel_i = 1'b0;
    clk_step();
    req_valid_i = 1'b0;
    clk_step();
    acc_req_ready_i = 2'b00; req_valid_i = 1'b1;
    clk_step();
    flush_i = 1'b1;
    #1;
    n_vec++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL flush_req_ready: got %b exp 0", req_ready_o); end
    n_vec++; if (acc_req_valid_o !== 2'b01) begin n_err++; $display("FAIL flush_buffered: got %b exp 01", acc_req_valid_o); end
    clk_step();
    flush_i = 1'b0; req_valid_i = 1'b0;
    n_vec++; if (acc_req_valid_o !== 2'b00) begin n_err++; $display("FAIL flush_dropped: got %b exp 00", acc_req_valid_o); end
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL flush_busy_outst: got %b exp 1", busy_o); end
    acc_resp_valid_i = 2'b01; resp_ready_i = 1'b1;
    clk_step();
    acc_resp_valid_i = 2'b00;
    n_vec++; if ({resp_valid_o, busy_o} !== 2'b10) begin n_err++; $display("FAIL flush_drain: got valid=%b busy=%b exp 1/0", resp_valid_o, busy_o); end
    req_valid_i = 1'b1;
    clk_step();
    req_valid_i = 1'b0; flush_i = 1'b1; acc_req_ready_i = 2'b01;
    clk_step();
    flush_i = 1'b0; acc_req_ready_i = 2'b00;
    n_vec++; if ({acc_req_valid_o, busy_o} !== 3'b001) begin n_err++; $display("FAIL flush_hs_issued: got valid=%b busy=%b exp 00/1", acc_req_valid_o, busy_o); end
    acc_resp_valid_i = 2'b01;
    clk_step();
    acc_resp_valid_i = 2'b00;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL flush_hs_drain: got %b exp 0", busy_o); end
  endtask

  task automatic test_issue_resp_same();
    do_reset();
    acc_req_ready_i = 2'b10; req_valid_i = 1'b1; req_sel_i = 1'b1;
    clk_step();
    clk_step();
    req_valid_i = 1'b0;
    clk_step();
    acc_req_ready_i = 2'b00; req_valid_i = 1'b1;
    clk_step();
    req_valid_i = 1'b0; acc_req_ready_i = 2'b10;
    acc_resp_valid_i = 2'b10; resp_ready_i = 1'b1;
    #1;
    n_vec++; if ({acc_req_valid_o, acc_resp_ready_o} !== 4'b1010) begin n_err++; $display("FAIL same_cycle_hs: got %b/%b exp 10/10", acc_req_valid_o, acc_resp_ready_o); end
    clk_step();
    acc_req_ready_i = 2'b00;
    clk_step();
    n_vec++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL same_cycle_left1: got %b exp 1", busy_o); end
    clk_step();
    acc_resp_valid_i = 2'b00;
    n_vec++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL same_cycle_left0: got %b exp 0", busy_o); end
  endtask

  task automatic test_perf();
    do_reset();
    acc_req_ready_i = 2'b00; req_valid_i = 1'b1; req_sel_i = 1'b0;
    clk_step();
    #1;
    n_vec++; if (req_ready_o !== 1'b0) begin n_err++; $display("FAIL perf_blocked: got %b exp 0", req_ready_o); end
    repeat (10) clk_step();
    req_valid_i = 1'b0;
    #1;
    n_vec++; if (perf_stall_o !== 32'(EXP_STALL)) begin n_err++; $display("FAIL perf_count: got %0d exp %0d", perf_stall_o, EXP_STALL); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    req_valid_i = 1'b1; req_sel_i = 1'b0;
    acc_resp_valid_i = 2'b10; acc_resp_data_i = {64'h77, 3'd3, 64'h0, 3'd0};
    clk_step();
    set_idle();
    #2 rst_i = 1'b1;
    #1;
    n_vec++; if ({resp_valid_o, acc_req_valid_o, busy_o} !== 4'b0000) begin n_err++; $display("FAIL midrst_clear: got %b/%b/%b exp 0/00/0", resp_valid_o, acc_req_valid_o, busy_o); end
    clk_step();
    rst_i = 1'b0;
    resp_ready_i = 1'b1;
    clk_step();
    n_vec++; if (resp_valid_o !== 1'b0) begin n_err++; $display("FAIL midrst_no_replay: got %b exp 0", resp_valid_o); end
  endtask

  task automatic test_random();
    bit             m_bv  [N];
    logic [RQW-1:0] m_bd  [N];
    int             m_out [N];
    bit             iss   [N];
    bit             m_rv;
    logic [RSW-1:0] m_rd;
    int             m_rch, m_ptr, gnt, s;
    bit             take, e_ready, e_busy, acc;
    logic [N-1:0]   e_gnt, e_bv;
    do_reset();
    for (int c = 0; c < N; c++) begin m_bv[c] = 0; m_bd[c] = '0; m_out[c] = 0; end
    m_rv = 0; m_rd = '0; m_rch = 0; m_ptr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      req_valid_i  = ($urandom_range(0, 3) != 0);
      req_sel_i    = 1'($urandom_range(0, N - 1));
      req_insn_i   = $urandom;
      req_rs1_i    = {$urandom, $urandom};
      req_rs2_i    = {$urandom, $urandom};
      req_tid_i    = 3'($urandom);
      flush_i      = ($urandom_range(0, 15) == 0);
      acc_req_ready_i = 2'($urandom);
      for (int c = 0; c < N; c++) begin
        acc_resp_valid_i[c] = (m_out[c] > 0) && ($urandom_range(0, 1) == 1);
        acc_resp_data_i[c*RSW +: RSW] = {$urandom, $urandom, 3'($urandom)};
      end
      resp_ready_i = ($urandom_range(0, 3) != 0);
      #1;
      s       = int'(req_sel_i);
      e_ready = !flush_i && !(m_bv[s] && !acc_req_ready_i[s]) && (m_out[s] + int'(m_bv[s]) < MAXO);
      take    = !m_rv || resp_ready_i;
      gnt     = -1;
      if (take) begin
        for (int i = 0; i < N; i++) begin
          int c;
          c = (m_ptr + i) % N;
          if (gnt < 0 && acc_resp_valid_i[c]) gnt = c;
        end
      end
      e_gnt  = '0;
      if (gnt >= 0) e_gnt[gnt] = 1'b1;
      e_busy = 0;
      for (int c = 0; c < N; c++) begin
        e_bv[c] = m_bv[c];
        if (m_bv[c] || m_out[c] > 0) e_busy = 1;
      end
      n_vec++; if (req_ready_o !== e_ready) begin n_err++; $display("FAIL rand_req_ready cyc%0d: got %b exp %b", cyc, req_ready_o, e_ready); end
      n_vec++; if (acc_resp_ready_o !== e_gnt) begin n_err++; $display("FAIL rand_grant cyc%0d: got %b exp %b", cyc, acc_resp_ready_o, e_gnt); end
      n_vec++; if (acc_req_valid_o !== e_bv) begin n_err++; $display("FAIL rand_acc_valid cyc%0d: got %b exp %b", cyc, acc_req_valid_o, e_bv); end
      for (int c = 0; c < N; c++) begin
        if (m_bv[c]) begin
          n_vec++; if (acc_req_data_o[c*RQW +: RQW] !== m_bd[c]) begin n_err++; $display("FAIL rand_acc_data cyc%0d ch%0d: got %h exp %h", cyc, c, acc_req_data_o[c*RQW +: RQW], m_bd[c]); end
        end
      end
      n_vec++; if (resp_valid_o !== m_rv) begin n_err++; $display("FAIL rand_resp_valid cyc%0d: got %b exp %b", cyc, resp_valid_o, m_rv); end
      if (m_rv) begin
        n_vec++; if ({resp_result_o, resp_tid_o, resp_ch_o} !== {m_rd, 1'(m_rch)}) begin n_err++; $display("FAIL rand_resp_data cyc%0d: got %h/%h/%h exp %h/%0d", cyc, resp_result_o, resp_tid_o, resp_ch_o, m_rd, m_rch); end
      end
      n_vec++; if (busy_o !== e_busy) begin n_err++; $display("FAIL rand_busy cyc%0d: got %b exp %b", cyc, busy_o, e_busy); end
      // reference model state advance for this clock edge
      acc = req_valid_i && e_ready;
      for (int c = 0; c < N; c++) begin
        iss[c]   = m_bv[c] && acc_req_ready_i[c];
        m_out[c] = m_out[c] + int'(iss[c]);
        if (gnt == c) m_out[c] = (m_out[c] > 0) ? m_out[c] - 1 : 0;
        if (acc && s == c) begin
          m_bv[c] = 1;
          m_bd[c] = {req_insn_i, req_rs1_i, req_rs2_i, req_tid_i};
        end else if (iss[c] || flush_i) begin
          m_bv[c] = 0;
        end
      end
      if (take) begin
        m_rv = (gnt >= 0);
        if (gnt >= 0) begin
          m_rd  = acc_resp_data_i[gnt*RSW +: RSW];
          m_rch = gnt;
          m_ptr = (gnt + 1) % N;
        end
      end
      clk_step();
    end
    set_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_credit();
    test_rr();
    test_flush();
    test_issue_resp_same();
    test_perf();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
